// File: rtl/hazard_pc_ctrl_pkg.sv
// Shared core definitions for the program-counter hazard controller.
// Holds the FSM state encoding and the core-wide width and step constants.
package hazard_pc_ctrl_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 4;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MC_BUSY  = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_pc_ctrl_hazard_detect.sv
// Register-dependency comparator between the instruction in ID and the one in EX.
// The hit output is raised only when EX actually writes a register that ID actually reads.
module hazard_detect
    import hazard_pc_ctrl_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_use1,
    input  logic          id_use2,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_wb_en,
    output logic          hit
);

    logic match1_s;
    logic match2_s;

    // Per-operand source/destination match
    always_comb begin
        match1_s = id_use1 & (id_rs1 == ex_rd);
        match2_s = id_use2 & (id_rs2 == ex_rd);
        hit      = ex_wb_en & (match1_s | match2_s);
    end

endmodule

// File: rtl/hazard_pc_ctrl.sv
// Next-PC generation with load-use and multi-cycle-EX stalls and taken-branch redirects.
// Outputs are combinational from the registered state/counter and the current inputs.
module hazard_pc_ctrl
    import hazard_pc_ctrl_pkg::*;
#(
    parameter int              XLEN     = hazard_pc_ctrl_pkg::XLEN,
    parameter int              REG_AW   = hazard_pc_ctrl_pkg::REG_AW,
    parameter int              LD_LAT   = 1,
    parameter int              MC_CW    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wb_en,
    input  logic              ex_is_load,
    input  logic              ex_br_taken,
    input  logic [XLEN-1:0]   ex_br_target,
    input  logic              ex_mc_start,
    input  logic [MC_CW-1:0]  ex_mc_lat,
    output logic [XLEN-1:0]   pcnext,
    output logic              add_stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_hold,
    output logic              busy
);

    // Counter must hold both LD_LAT-2 (up to 5) and the multi-cycle latency
    localparam int CW = (MC_CW > 3) ? MC_CW : 3;

    state_e          state_r;
    state_e          state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic            hit_s;
    logic            load_use_s;
    logic            mc_go_s;
    logic [XLEN-1:0] pc_inc_s;

    hazard_detect #(.AW(REG_AW)) u_detect (
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .id_use1  (id_use1),
        .id_use2  (id_use2),
        .ex_rd    (ex_rd),
        .ex_wb_en (ex_wb_en),
        .hit      (hit_s)
    );

    // Event qualification and sequential PC increment (wraps modulo 2**XLEN)
    always_comb begin
        pc_inc_s   = pc + XLEN'(PC_STEP);
        load_use_s = ex_is_load & hit_s;
        mc_go_s    = ex_mc_start & (ex_mc_lat > MC_CW'(1));
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pcnext       = pc_inc_s;
        add_stall    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        busy         = 1'b0;
        if (rst) begin
            pcnext       = RESET_PC;
            state_next_s = RUN;
            cnt_next_s   = '0;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_br_taken) begin
                        pcnext       = ex_br_target;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (mc_go_s) begin
                        pcnext    = pc;
                        add_stall = 1'b1;
                        ex_hold   = 1'b1;
                        // Episode lasts lat-1 cycles: this one plus lat-2 in MC_BUSY,
                        // so MC_BUSY is loaded with the count of cycles after its first
                        if (ex_mc_lat > MC_CW'(2)) begin
                            cnt_next_s   = CW'(ex_mc_lat) - CW'(3);
                            state_next_s = MC_BUSY;
                        end else begin
                            state_next_s = RUN;
                        end
                    end else if (load_use_s) begin
                        pcnext       = pc;
                        add_stall    = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (LD_LAT > 1) begin
                            cnt_next_s   = CW'(LD_LAT - 2);
                            state_next_s = LD_STALL;
                        end else begin
                            state_next_s = RUN;
                        end
                    end else begin
                        state_next_s = RUN;
                    end
                end
                LD_STALL: begin
                    pcnext       = pc;
                    id_ex_bubble = 1'b1;
                    busy         = 1'b1;
                    if (cnt_r == CW'(0)) begin
                        state_next_s = RUN;
                    end else begin
                        cnt_next_s = cnt_r - CW'(1);
                    end
                end
                MC_BUSY: begin
                    pcnext  = pc;
                    ex_hold = 1'b1;
                    busy    = 1'b1;
                    if (cnt_r == CW'(0)) begin
                        state_next_s = RUN;
                    end else begin
                        cnt_next_s = cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_next_s = RUN;
                    cnt_next_s   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_pc_ctrl.sv
// Directed self-checking bench: one DUT with LD_LAT=1 and one with LD_LAT=3 share the stimulus.
module tb_hazard_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use1, id_use2, ex_wb_en, ex_is_load, ex_br_taken, ex_mc_start;
    logic [31:0] ex_br_target;
    logic [3:0]  ex_mc_lat;

    logic [31:0] pcn_a, pcn_b;
    logic        st_a, fl_a, bb_a, hd_a, by_a;
    logic        st_b, fl_b, bb_b, hd_b, by_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_pc_ctrl #(.LD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .pc(pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_mc_start(ex_mc_start), .ex_mc_lat(ex_mc_lat),
        .pcnext(pcn_a), .add_stall(st_a), .if_id_flush(fl_a),
        .id_ex_bubble(bb_a), .ex_hold(hd_a), .busy(by_a)
    );

    hazard_pc_ctrl #(.LD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .pc(pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_mc_start(ex_mc_start), .ex_mc_lat(ex_mc_lat),
        .pcnext(pcn_b), .add_stall(st_b), .if_id_flush(fl_b),
        .id_ex_bubble(bb_b), .ex_hold(hd_b), .busy(by_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // flags order: add_stall, if_id_flush, id_ex_bubble, ex_hold, busy
    task automatic flags_a(input string tag, input logic [4:0] exp);
        chk({tag, ".a.flags"}, {27'd0, st_a, fl_a, bb_a, hd_a, by_a}, {27'd0, exp});
    endtask

    task automatic flags_b(input string tag, input logic [4:0] exp);
        chk({tag, ".b.flags"}, {27'd0, st_b, fl_b, bb_b, hd_b, by_b}, {27'd0, exp});
    endtask

    task automatic idle();
        id_rs1 = 4'd0; id_rs2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_rd = 4'd0; ex_wb_en = 1'b0; ex_is_load = 1'b0;
        ex_br_taken = 1'b0; ex_br_target = 32'd0;
        ex_mc_start = 1'b0; ex_mc_lat = 4'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_hit();
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd = 4'd3;
        id_rs1 = 4'd3; id_use1 = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        pc  = 32'h40;

        // 1: reset, then release
        tick();
        chk("rst1.pcnext", pcn_a, 32'h0);
        flags_a("rst1", 5'b00000);
        tick();
        chk("rst2.pcnext", pcn_a, 32'h0);
        flags_b("rst2", 5'b00000);
        rst = 1'b0;
        #1;
        chk("run.pcnext", pcn_a, 32'h44);
        flags_a("run", 5'b00000);

        // 2: load-use hit on rs1
        tick();
        pc = 32'h100;
        set_load_hit();
        #1;
        flags_a("ld.c1", 5'b10100);
        flags_b("ld.c1", 5'b10100);
        tick();
        idle();
        #1;
        chk("ld.c2.a.pcnext", pcn_a, 32'h104);
        flags_a("ld.c2", 5'b00000);
        chk("ld.c2.b.pcnext", pcn_b, 32'h100);
        flags_b("ld.c2", 5'b00101);
        tick();
        flags_b("ld.c3", 5'b00101);
        tick();
        chk("ld.c4.b.pcnext", pcn_b, 32'h104);
        flags_b("ld.c4", 5'b00000);

        // rs2 path hit, non-load hit, unqualified write-back
        ex_is_load = 1'b1; ex_wb_en = 1'b1; ex_rd = 4'd9;
        id_rs2 = 4'd9; id_use2 = 1'b1;
        #1;
        flags_a("ld.rs2", 5'b10100);
        ex_is_load = 1'b0;
        #1;
        flags_a("fwd", 5'b00000);
        chk("fwd.pcnext", pcn_a, 32'h104);
        ex_is_load = 1'b1; ex_wb_en = 1'b0;
        #1;
        flags_a("nowb", 5'b00000);
        ex_wb_en = 1'b1; id_use2 = 1'b0;
        #1;
        flags_a("nouse", 5'b00000);
        idle();

        // 3: taken branch with a simultaneous load-use hit
        pc = 32'h180;
        set_load_hit();
        ex_br_taken = 1'b1; ex_br_target = 32'h200;
        #1;
        chk("br.a.pcnext", pcn_a, 32'h200);
        flags_a("br", 5'b01100);
        chk("br.b.pcnext", pcn_b, 32'h200);
        flags_b("br", 5'b01100);
        tick();
        idle();
        pc = 32'h200;
        #1;
        chk("br.after.b.pcnext", pcn_b, 32'h204);
        flags_b("br.after", 5'b00000);

        // 4: multi-cycle op, lat=5, with a branch arriving mid-episode
        pc = 32'h300;
        ex_mc_start = 1'b1; ex_mc_lat = 4'd5;
        #1;
        flags_a("mc.c1", 5'b10010);
        tick();
        idle();
        #1;
        chk("mc.c2.pcnext", pcn_a, 32'h300);
        flags_a("mc.c2", 5'b00011);
        tick();
        ex_br_taken = 1'b1; ex_br_target = 32'h999;
        #1;
        chk("mc.c3.pcnext", pcn_a, 32'h300);
        flags_a("mc.c3", 5'b00011);
        tick();
        idle();
        #1;
        chk("mc.c4.pcnext", pcn_a, 32'h300);
        flags_a("mc.c4", 5'b00011);
        tick();
        chk("mc.c5.pcnext", pcn_a, 32'h304);
        flags_a("mc.c5", 5'b00000);

        // multi-cycle boundaries: lat=2 one stall cycle, lat=1 none
        ex_mc_start = 1'b1; ex_mc_lat = 4'd2;
        #1;
        flags_a("mc2.c1", 5'b10010);
        tick();
        idle();
        #1;
        flags_a("mc2.c2", 5'b00000);
        ex_mc_start = 1'b1; ex_mc_lat = 4'd1;
        #1;
        flags_a("mc1", 5'b00000);
        chk("mc1.pcnext", pcn_a, 32'h304);
        idle();

        // 5: PC wrap, then reset during MC_BUSY
        pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap.pcnext", pcn_a, 32'h0);
        pc = 32'h500;
        ex_mc_start = 1'b1; ex_mc_lat = 4'd6;
        tick();
        idle();
        #1;
        flags_a("mcrst.busy", 5'b00011);
        rst = 1'b1;
        #1;
        chk("mcrst.in.pcnext", pcn_a, 32'h0);
        flags_a("mcrst.in", 5'b00000);
        tick();
        rst = 1'b0;
        #1;
        chk("mcrst.out.pcnext", pcn_a, 32'h504);
        flags_a("mcrst.out", 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
